vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
Scan-out controller for the VGA side of the cam2vga path. It generates HSYNC/VSYNC timing in the vga_clk domain and pulls RGB565 pixels from the upstream frame FIFO, which is first-word fall-through. It aligns FIFO frames to the raster using a start-of-frame tag, and it detects and recovers from underflow. Its outputs drive the VGA pins directly: VSYNC_Sig, HSYNC_Sig, Red_Sig, Green_Sig and Blue_Sig. A 16-bit bus is reconstructed from them as {R,G,B}.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HSYNC pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scan-out enable; sampled each clock
- pix_data  in  16  FIFO head word, RGB565 = {R[4:0],G[5:0],B[4:0]}; valid when !pix_empty
- pix_sof  in  1  FIFO head tag; marks the first pixel of a frame
- pix_empty  in  1  FIFO empty
- pix_rd  out  1  FIFO pop (combinational from state/counters/pix_empty)
- HSYNC_Sig  out  1  horizontal sync
- VSYNC_Sig  out  1  vertical sync
- Red_Sig  out  5  red
- Green_Sig  out  6  green
- Blue_Sig  out  5  blue
- underflow  out  1  sticky error; cleared only by reset
- frame_done  out  1  one-clock pulse when the last active pixel of an aligned frame is output

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Counter widths are $clog2 of the totals.
- h_cnt and v_cnt free-run from reset, independent of enable.
  - h_cnt wraps at H_TOTAL-1 to 0.
  - v_cnt increments on the h_cnt wrap and wraps at V_TOTAL-1 to 0.
- Region order per line and per frame: active, FP, sync, BP.
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - HSYNC is asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; VSYNC uses the same rule on v_cnt.
- All pin outputs are registered, with 1-clock latency from the counters. Sync and RGB for counter value N appear together on cycle N+1.
- Reset values:
  - h_cnt = 0, v_cnt = 0, state = IDLE.
  - HSYNC_Sig and VSYNC_Sig = !SYNC_POL.
  - RGB = 0, pix_rd = 0, underflow = 0, frame_done = 0.
- State machine:
  - IDLE: RGB = 0, no pops. Goes to SEEK when enable = 1.
  - SEEK: pop every clock while !pix_empty && !pix_sof, discarding stale words. Goes to WAIT_VS when !pix_empty && pix_sof; the sof word is not popped.
  - WAIT_VS: no pops, RGB = 0. Goes to RUN on the cycle where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, so pixel (0,0) is the first RUN pixel.
  - RUN, when act and !pix_empty:
    - Normally pix_rd = 1 and RGB is registered from pix_data.
    - If pix_sof = 1 at a pixel other than (0,0), this is misalignment. Do not pop, output 0, set underflow, go to WAIT_VS.
  - RUN, when act and pix_empty: this is underflow. Output RGB = 0, set underflow, go to SEEK.
  - RUN outside act: RGB = 0, no pops.
  - frame_done is asserted with the output of pixel (H_ACTIVE-1, V_ACTIVE-1) in RUN.
- enable = 0 in any state: go to IDLE on the next clock. The pop for the current cycle still completes. Syncs continue.
- Simultaneous events:
  - Underflow on the last active pixel sets underflow, and frame_done is not pulsed.
  - When enable drops, enable = 0 has priority over all other transitions.
- Asynchronous reset mid-line forces all reset values immediately. The counters restart at (0,0).

Decomposition:
- Package vga_pkg:
  - Default timing constants for 640x480@60.
  - Typedef enum logic [1:0] scan_state_e {IDLE, SEEK, WAIT_VS, RUN}.
  - Typedef rgb565_t as a packed struct {r[4:0], g[5:0], b[4:0]}.
- Sub-module vga_timing_gen: h/v counters, act, registered syncs, and frame-wrap / pixel-position strobes.
- vga_scan_ctrl holds the FSM, FIFO pop logic and RGB register.

Test Plan:
- Reset then enable = 0 for 2 frames:
  - HSYNC low for 96 clocks every 800; VSYNC low for 2 lines every 525.
  - RGB = 0, pix_rd never asserted.
- FIFO preloaded with 3 junk words then a full frame (sof on word 0, pixel value = index), enable = 1:
  - 3 pops in SEEK, then the frame starts at the next (0,0).
  - Output pixel (0,0) = 0x0000 and (1,0) = 0x0001, one clock after the counters.
  - frame_done pulses once.
- Pixel 0xF81F:
  - Red_Sig = 5'h1F, Green_Sig = 6'h00, Blue_Sig = 5'h1F.
  - The {R,G,B} reconstruction equals 0xF81F.
- FIFO runs empty at pixel (100,5):
  - That pixel outputs 0 and underflow = 1 (sticky).
  - State goes to SEEK; the next sof-tagged frame resumes at (0,0) of the following frame.
- sof arrives at pixel (10,0):
  - underflow set, no pop at that pixel.
  - Next frame starts from that sof word at (0,0).
- Async reset asserted at h_cnt = 300: all outputs reach reset values without a clock edge, and counters restart at 0 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults (640x480@60), scan FSM states and RGB565 pixel type.
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {IDLE, SEEK, WAIT_VS, RUN} scan_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters, registered sync outputs and position strobes.
// Ports: vga_clk/rst (async, active-high); act = inside visible area; first_pix = (0,0);
// last_pix = last visible pixel; frame_wrap = final count of the frame; hsync/vsync registered.
import vga_pkg::*;

module vga_timing_gen #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic vga_clk,
    input  logic rst,
    output logic act,
    output logic first_pix,
    output logic last_pix,
    output logic frame_wrap,
    output logic hsync,
    output logic vsync
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic h_end, v_end;

    assign h_end      = h_cnt == H_LAST;
    assign v_end      = v_cnt == V_LAST;
    assign act        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign first_pix  = (h_cnt == '0) && (v_cnt == '0);
    assign last_pix   = (h_cnt == H_ACT - 1'b1) && (v_cnt == V_ACT - 1'b1);
    assign frame_wrap = h_end && v_end;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= !SYNC_POL;
            vsync <= !SYNC_POL;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            hsync <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : !SYNC_POL;
            vsync <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : !SYNC_POL;
        end
    end
endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA scan-out; aligns FWFT FIFO frames to the raster by sof tag, recovers from underflow.
// Ports: vga_clk/rst (async, active-high); enable; pix_data/pix_sof/pix_empty = FIFO head;
// pix_rd = FIFO pop; HSYNC_Sig/VSYNC_Sig/Red_Sig/Green_Sig/Blue_Sig = registered VGA pins;
// underflow = sticky error; frame_done = pulse with the last visible pixel of an aligned frame.
import vga_pkg::*;

module vga_scan_ctrl #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_empty,
    output logic        pix_rd,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic [4:0]  Red_Sig,
    output logic [5:0]  Green_Sig,
    output logic [4:0]  Blue_Sig,
    output logic        underflow,
    output logic        frame_done
);
    scan_state_e state, state_nx;
    rgb565_t     rgb;
    logic        act, first_pix, last_pix, frame_wrap;
    logic        run_act, bad_sof, starve;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .act       (act),
        .first_pix (first_pix),
        .last_pix  (last_pix),
        .frame_wrap(frame_wrap),
        .hsync     (HSYNC_Sig),
        .vsync     (VSYNC_Sig)
    );

    // An sof tag anywhere but (0,0) means the FIFO frame slipped against the raster.
    assign run_act = (state == RUN) && act;
    assign bad_sof = run_act && !pix_empty && pix_sof && !first_pix;
    assign starve  = run_act && pix_empty;
    assign pix_rd  = ((state == SEEK) && !pix_empty && !pix_sof) ||
                     (run_act && !pix_empty && !bad_sof);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = SEEK;
            SEEK:    state_nx = (!pix_empty && pix_sof) ? WAIT_VS : SEEK;
            WAIT_VS: state_nx = frame_wrap ? RUN : WAIT_VS;
            RUN:     state_nx = starve ? SEEK : bad_sof ? WAIT_VS : RUN;
            default: state_nx = IDLE;
        endcase
        if (!enable)
            state_nx = IDLE;
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rgb        <= '0;
            underflow  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            rgb        <= ((state == RUN) && pix_rd) ? rgb565_t'(pix_data) : '0;
            underflow  <= underflow || starve || bad_sof;
            frame_done <= (state == RUN) && pix_rd && last_pix;
        end
    end

    assign Red_Sig   = rgb.r;
    assign Green_Sig = rgb.g;
    assign Blue_Sig  = rgb.b;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: randomized self-checking bench with a FIFO queue and a raster-arithmetic reference model.
module tb_vga_scan_ctrl;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit POL = 1'b0;
    localparam int LIM = 4 * HT * VT;
    localparam int P_OFF = 0, P_HUNT = 1, P_ARMED = 2, P_SHOW = 3;

    logic        clk, rst, en;
    logic [15:0] pix_data;
    logic        pix_sof, pix_empty;
    logic        pix_rd, HSYNC_Sig, VSYNC_Sig, underflow, frame_done;
    logic [4:0]  Red_Sig, Blue_Sig;
    logic [5:0]  Green_Sig;

    logic [16:0] fq[$];
    int checks, errors, t, phase, fd_cnt, hunt_pops, rd_cnt, hs_low, vs_low;
    int last_h, last_v, uf_h, uf_v;
    bit m_uf, rd_at;
    logic [15:0] p00, p10;

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
    ) dut (
        .vga_clk(clk), .rst(rst), .enable(en),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_empty(pix_empty),
        .pix_rd(pix_rd), .HSYNC_Sig(HSYNC_Sig), .VSYNC_Sig(VSYNC_Sig),
        .Red_Sig(Red_Sig), .Green_Sig(Green_Sig), .Blue_Sig(Blue_Sig),
        .underflow(underflow), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        pix_empty = fq.size() == 0;
        {pix_sof, pix_data} = pix_empty ? 17'h0 : fq[0];
    endtask

    task automatic clear_model();
        t = 0; phase = P_OFF; m_uf = 0;
        fd_cnt = 0; hunt_pops = 0; rd_cnt = 0; hs_low = 0; vs_low = 0;
        uf_h = -1; uf_v = -1; rd_at = 1'b1; p00 = 16'hdead; p10 = 16'hdead;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0;
        fq.delete(); refresh();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) fq.push_back({1'b0, 16'($urandom)});
        refresh();
    endtask

    task automatic push_frame(input logic [15:0] base, input bit rnd, input int n);
        for (int i = 0; i < n; i++)
            fq.push_back({i == 0, rnd ? 16'($urandom) : base + 16'(i)});
        refresh();
    endtask

    // One pixel clock: the model predicts the pop for this cycle and the pins after the edge.
    task automatic tick();
        int h, v, nx;
        bit a, e, hsof, xrd, xfd, xhs, xvs, obs_rd, was_uf;
        logic [15:0] hd, xrgb;
        #3;
        h = t % HT; v = (t / HT) % VT;
        a = h < HA && v < VA;
        e = fq.size() == 0;
        hsof = e ? 1'b0 : fq[0][16];
        hd = e ? 16'h0 : fq[0][15:0];
        xrd = 0; xfd = 0; xrgb = 16'h0; nx = phase;
        if (phase == P_OFF) nx = P_HUNT;
        else if (phase == P_HUNT && !e) begin
            if (hsof) nx = P_ARMED; else xrd = 1;
        end else if (phase == P_ARMED && h == HT - 1 && v == VT - 1) nx = P_SHOW;
        else if (phase == P_SHOW && a) begin
            if (e) begin m_uf = 1; nx = P_HUNT; end
            else if (hsof && (h != 0 || v != 0)) begin m_uf = 1; nx = P_ARMED; end
            else begin xrd = 1; xrgb = hd; xfd = (h == HA - 1 && v == VA - 1); end
        end
        if (!en) nx = P_OFF;
        xhs = (h >= HA + HF && h < HA + HF + HS) ? POL : !POL;
        xvs = (v >= VA + VF && v < VA + VF + VS) ? POL : !POL;
        obs_rd = pix_rd;
        was_uf = underflow;
        checks++;
        if (obs_rd !== xrd) begin
            errors++;
            $display("FAIL pix_rd t=%0d h=%0d v=%0d got %b exp %b", t, h, v, obs_rd, xrd);
        end
        @(posedge clk); #1;
        if (obs_rd && !e) void'(fq.pop_front());
        refresh();
        checks++;
        if ({HSYNC_Sig, VSYNC_Sig, Red_Sig, Green_Sig, Blue_Sig, frame_done, underflow} !==
            {xhs, xvs, xrgb, xfd, m_uf}) begin
            errors++;
            $display("FAIL pins t=%0d h=%0d v=%0d got hs=%b vs=%b rgb=%h fd=%b uf=%b exp hs=%b vs=%b rgb=%h fd=%b uf=%b",
                     t, h, v, HSYNC_Sig, VSYNC_Sig, {Red_Sig, Green_Sig, Blue_Sig}, frame_done, underflow,
                     xhs, xvs, xrgb, xfd, m_uf);
        end
        if (obs_rd) rd_cnt++;
        if (obs_rd && phase == P_HUNT) hunt_pops++;
        if (frame_done === 1'b1) fd_cnt++;
        if (HSYNC_Sig === 1'b0) hs_low++;
        if (VSYNC_Sig === 1'b0) vs_low++;
        if (xrd && phase == P_SHOW && h == 0 && v == 0) p00 = {Red_Sig, Green_Sig, Blue_Sig};
        if (xrd && phase == P_SHOW && h == 1 && v == 0) p10 = {Red_Sig, Green_Sig, Blue_Sig};
        if (!was_uf && underflow === 1'b1) begin uf_h = h; uf_v = v; rd_at = obs_rd; end
        last_h = h; last_v = v;
        phase = nx;
        t++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; fq.delete(); refresh();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (HSYNC_Sig !== !POL) begin errors++; $display("FAIL reset_hsync got %b exp %b", HSYNC_Sig, !POL); end
        checks++; if (VSYNC_Sig !== !POL) begin errors++; $display("FAIL reset_vsync got %b exp %b", VSYNC_Sig, !POL); end
        checks++; if ({Red_Sig, Green_Sig, Blue_Sig} !== 16'h0) begin errors++; $display("FAIL reset_rgb got %h exp 0000", {Red_Sig, Green_Sig, Blue_Sig}); end
        checks++; if (pix_rd !== 1'b0) begin errors++; $display("FAIL reset_pix_rd got %b exp 0", pix_rd); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_idle();
        push_junk(4);
        for (int i = 0; i < 2 * HT * VT; i++) tick();
        checks++; if (hs_low != 2 * VT * HS) begin errors++; $display("FAIL idle_hsync_low got %0d exp %0d", hs_low, 2 * VT * HS); end
        checks++; if (vs_low != 2 * VS * HT) begin errors++; $display("FAIL idle_vsync_low got %0d exp %0d", vs_low, 2 * VS * HT); end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL idle_pops got %0d exp 0", rd_cnt); end
    endtask

    task automatic test_frame();
        do_reset();
        push_junk(3);
        push_frame(16'h0, 1'b0, HA * VA);
        en = 1'b1;
        for (int i = 0; i < LIM && fd_cnt == 0; i++) tick();
        en = 1'b0;
        repeat (5) tick();
        checks++; if (hunt_pops != 3) begin errors++; $display("FAIL frame_seek_pops got %0d exp 3", hunt_pops); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_count got %0d exp 1", fd_cnt); end
        checks++; if (p00 !== 16'h0000) begin errors++; $display("FAIL frame_pix00 got %h exp 0000", p00); end
        checks++; if (p10 !== 16'h0001) begin errors++; $display("FAIL frame_pix10 got %h exp 0001", p10); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL frame_underflow got %b exp 0", underflow); end
    endtask

    task automatic test_color();
        do_reset();
        fq.push_back({1'b1, 16'hF81F});
        push_frame(16'h0, 1'b1, HA * VA - 1);
        fq[1][16] = 1'b0;
        en = 1'b1;
        for (int i = 0; i < LIM && fd_cnt == 0; i++) begin
            tick();
            if (phase == P_SHOW && last_h == 0 && last_v == 0 && t % HT == 1) begin
                checks++; if (Red_Sig !== 5'h1F) begin errors++; $display("FAIL color_red got %h exp 1f", Red_Sig); end
                checks++; if (Green_Sig !== 6'h00) begin errors++; $display("FAIL color_green got %h exp 00", Green_Sig); end
                checks++; if (Blue_Sig !== 5'h1F) begin errors++; $display("FAIL color_blue got %h exp 1f", Blue_Sig); end
            end
        end
        en = 1'b0;
        repeat (3) tick();
        checks++; if (p00 !== 16'hF81F) begin errors++; $display("FAIL color_rgb565 got %h exp f81f", p00); end
    endtask

    task automatic test_underflow();
        do_reset();
        push_frame(16'h0, 1'b0, 3 * HA + 5);
        en = 1'b1;
        for (int i = 0; i < LIM && underflow !== 1'b1; i++) tick();
        checks++; if (uf_h != 5 || uf_v != 3) begin errors++; $display("FAIL underflow_pos got (%0d,%0d) exp (5,3)", uf_h, uf_v); end
        push_junk(2);
        push_frame(16'h0100, 1'b0, HA * VA);
        for (int i = 0; i < LIM && fd_cnt == 0; i++) tick();
        en = 1'b0;
        repeat (3) tick();
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL underflow_recover_done got %0d exp 1", fd_cnt); end
        checks++; if (p00 !== 16'h0100) begin errors++; $display("FAIL underflow_resume_pix00 got %h exp 0100", p00); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b exp 1", underflow); end
    endtask

    task automatic test_misalign();
        do_reset();
        push_frame(16'h0200, 1'b0, 10);
        push_frame(16'h0300, 1'b0, HA * VA);
        en = 1'b1;
        for (int i = 0; i < LIM && underflow !== 1'b1; i++) tick();
        checks++; if (uf_h != 10 || uf_v != 0) begin errors++; $display("FAIL misalign_pos got (%0d,%0d) exp (10,0)", uf_h, uf_v); end
        checks++; if (rd_at !== 1'b0) begin errors++; $display("FAIL misalign_pop got %b exp 0", rd_at); end
        for (int i = 0; i < LIM && fd_cnt == 0; i++) tick();
        en = 1'b0;
        repeat (3) tick();
        checks++; if (p00 !== 16'h0300) begin errors++; $display("FAIL misalign_resume_pix00 got %h exp 0300", p00); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL misalign_done got %0d exp 1", fd_cnt); end
    endtask

    task automatic test_random_enable();
        do_reset();
        push_junk($urandom_range(0, 5));
        push_frame(16'h0, 1'b1, HA * VA);
        push_frame(16'h0, 1'b1, HA * VA);
        en = 1'b1;
        for (int i = 0; i < 3 * HT * VT; i++) begin
            if ($urandom_range(0, 99) < 2) en = !en;
            tick();
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        push_frame(16'h0, 1'b0, 2);
        en = 1'b1;
        for (int i = 0; i < LIM && underflow !== 1'b1; i++) tick();
        for (int i = 0; i < HT && !(last_h == HA + HF + 1); i++) tick();
        checks++; if (HSYNC_Sig !== POL || underflow !== 1'b1) begin
            errors++; $display("FAIL areset_pre got hs=%b uf=%b exp hs=%b uf=1", HSYNC_Sig, underflow, POL);
        end
        #3 rst = 1'b1;
        #1;
        checks++; if (HSYNC_Sig !== !POL) begin errors++; $display("FAIL areset_hsync got %b exp %b", HSYNC_Sig, !POL); end
        checks++; if (VSYNC_Sig !== !POL) begin errors++; $display("FAIL areset_vsync got %b exp %b", VSYNC_Sig, !POL); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL areset_underflow got %b exp 0", underflow); end
        checks++; if ({Red_Sig, Green_Sig, Blue_Sig, frame_done, pix_rd} !== 18'h0) begin
            errors++; $display("FAIL areset_rgb_fd_rd got %h exp 0", {Red_Sig, Green_Sig, Blue_Sig, frame_done, pix_rd});
        end
        fq.delete(); refresh();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 3 * HT; i++) tick();
        en = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; en = 1'b0;
        clear_model();
        refresh();
        test_reset();
        test_idle();
        test_frame();
        test_color();
        test_underflow();
        test_misalign();
        test_random_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
